// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder built from two half-adder cells plus an OR.
module full_adder_bit (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .in_1  (in_1),
    .in_2  (in_2),
    .sum   (s0),
    .carry (c0)
  );

  half_adder u_ha1 (
    .in_1  (s0),
    .in_2  (cin),
    .sum   (sum),
    .carry (c1)
  );

  assign carry = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Existing 1-bit half-adder cell.
module half_adder (
  input  logic in_1,
  input  logic in_2,
  output logic sum,
  output logic carry
);

  assign sum   = in_1 ^ in_2;
  assign carry = in_1 & in_2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input for in_1 - in_2.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t          state;
  state_t          state_nxt;
  logic            load;
  logic            shift;
  logic            finish;
  logic            sub_eff;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic            c;
  logic [CW-1:0]   cnt;
  logic            s_bit;
  logic            c_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  full_adder_bit u_fa (
    .in_1  (a_sr[0]),
    .in_2  (b_sr[0]),
    .cin   (c),
    .sum   (s_bit),
    .carry (c_bit)
  );

  assign r_nxt = {s_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        shift = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (load) begin
        a_sr <= in_1;
        b_sr <= sub_eff ? ~in_2 : in_2;
        c    <= sub_eff;
        cnt  <= '0;
      end else if (shift) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= r_nxt;
        c    <= c_bit;
        cnt  <= cnt + CW'(1);
      end
      // Result registers update only when the last bit is produced.
      if (finish) begin
        sum   <= r_nxt;
        carry <= c_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a transaction-level model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .in_1  (in_1),
    .in_2  (in_2),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a transaction occupies WIDTH busy cycles then one done cycle.
  bit           armed = 0;
  bit           m_busy = 0;
  bit           m_done = 0;
  logic [W-1:0] m_sum = '0;
  bit           m_carry = 0;
  int           left = 0;
  logic [W-1:0] pend_sum;
  bit           pend_carry;

  always @(posedge clk) begin
    bit sub_v;
    int total;
`ifdef SERIAL_ADDER_SUB_EN
    sub_v = sub;
`else
    sub_v = 1'b0;
`endif
    if (reset) begin
      m_busy = 0; m_done = 0; m_sum = '0; m_carry = 0; left = 0; armed = 1;
    end else if (m_busy) begin
      m_done = 0;
      left--;
      if (left == 0) begin
        m_busy = 0; m_done = 1; m_sum = pend_sum; m_carry = pend_carry;
      end
    end else begin
      m_done = 0;
      if (start) begin
        if (sub_v) begin
          pend_sum   = in_1 - in_2;
          pend_carry = (in_1 >= in_2);
        end else begin
          total      = int'(in_1) + int'(in_2);
          pend_sum   = W'(total);
          pend_carry = (total >= (1 << W));
        end
        left = W; m_busy = 1;
      end
    end
    #1;
    if (armed) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("sum", 32'(sum), 32'(m_sum));
      chk("carry", 32'(carry), 32'(m_carry));
    end
  end

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sb, input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    start = 1'b1; in_1 = a; in_2 = b; sub = sb;
    @(negedge clk);
    start = 1'b0; in_1 = W'($urandom); in_2 = W'($urandom);
    wait_done(1, n);
    chk({name, "_latency"}, 32'(n), 32'(W + 1));
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_carry"}, 32'(carry), 32'(ec));
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; sub = 1'b0; in_1 = '0; in_2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    reset = 1'b0;

    run_op("basic", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    run_op("ovf1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ovf2", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

    // Start pulse during RUN is ignored.
    @(negedge clk);
    start = 1'b1; in_1 = 8'h05; in_2 = 8'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; in_1 = 8'h11; in_2 = 8'h22;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n);
    chk("ignore_latency", 32'(n), 32'd9);
    chk("ignore_sum", 32'(sum), 32'h08);
    repeat (12) @(negedge clk);
    chk("ignore_no_done", 32'(done), 32'd0);

    // Back-to-back with start held.
    @(negedge clk);
    start = 1'b1; in_1 = 8'h10; in_2 = 8'h20;
    @(negedge clk);
    in_1 = 8'h7F; in_2 = 8'h01;
    wait_done(1, n);
    chk("b2b_first_cycle", 32'(n), 32'd9);
    chk("b2b_first_sum", 32'(sum), 32'h30);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_hold_sum", 32'(sum), 32'h30);
    wait_done(10, n);
    chk("b2b_second_cycle", 32'(n), 32'd18);
    chk("b2b_second_sum", 32'(sum), 32'h80);
    chk("b2b_second_carry", 32'(carry), 32'd0);

    // Reset in the middle of a RUN.
    @(negedge clk);
    start = 1'b1; in_1 = 8'h40; in_2 = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carry", 32'(carry), 32'd0);
    run_op("after_rst", 8'h02, 8'h02, 1'b0, 8'h04, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_neg", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
    run_op("sub_pos", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`endif

    // Random traffic: starts at any time, occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      in_1  = W'($urandom);
      in_2  = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub   = 1'($urandom);
`endif
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder; the sequential stage wrapped around the team's 1-bit adder cell.
- Accepts two WIDTH-bit operands on a start strobe and streams them LSB-first through a single full-adder cell, one bit per clock.
- Carries between bits in a flip-flop, assembles sum LSB-first, and presents a registered WIDTH-bit sum plus carry-out with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- in_1  input  WIDTH  operand A; captured on the accepting edge only.
- in_2  input  WIDTH  operand B; captured on the accepting edge only.
- busy  output  1  high while state == RUN.
- done  output  1  one-cycle pulse; sum/carry valid from this cycle on.
- sum  output  WIDTH  registered result.
- carry  output  1  registered carry-out of MSB.

Behaviour:
- Reset (sync, checked each edge, overrides everything, including mid-RUN):
  - state = IDLE; busy = 0, done = 0, sum = 0, carry = 0.
  - Internal shift registers, carry flop and bit counter cleared.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start = 1 -> load in_1/in_2 into shift regs a_sr/b_sr, clear carry flop c, clear counter cnt, go to RUN.
  - Otherwise stay in IDLE.
- RUN, every edge:
  - s = a_sr[0] ^ b_sr[0] ^ c; c <= majority(a_sr[0], b_sr[0], c).
  - s shifted into the MSB of result shift reg r_sr (right shift); a_sr and b_sr shift right.
  - cnt increments.
  - On the edge where cnt == WIDTH-1: sum <= final r_sr, carry <= final carry-out, go to DONE.
  - start is ignored throughout RUN.
- DONE: lasts exactly one cycle with done = 1.
  - start = 1 -> accepted exactly as in IDLE (back-to-back operation, no idle bubble).
  - Otherwise go to IDLE.
- Latency: start high in cycle 0 -> busy high in cycles 1..WIDTH -> done high in cycle WIDTH+1.
- Throughput: one result per WIDTH+1 cycles when start is held.
- Output hold rules:
  - sum/carry change only on the RUN->DONE edge or on reset.
  - They hold the previous result through a subsequent RUN.
  - in_1/in_2 may change freely after the accepting edge.
- Arithmetic: modulo 2^WIDTH; carry = bit WIDTH of the full sum. Example: 0xFF+0x01 -> sum 0x00, carry 1.
- Counter width: clog2(WIDTH); it must not wrap before its terminal compare.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands.
  - sub = 1 -> b_sr loads ~in_2 and c is preset to 1, so the result is in_1 - in_2 mod 2^WIDTH.
  - carry = 1 means no borrow (in_1 >= in_2 unsigned).
  - sub = 0 -> identical to the undefined case.
- Undefined: no sub port, addition only.

Decomposition:
- Package serial_adder_pkg:
  - state typedef/localparams S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2.
  - Default WIDTH constant.
- One sub-module, full_adder_bit:
  - Inputs in_1, in_2, cin; outputs sum, carry; purely combinational.
  - Built from two instances of the existing half-adder cell plus an OR.
  - Instantiated once in the datapath.

Test Plan (WIDTH=8):
- Basic add: reset 2 cycles, then start with in_1 = 0x05, in_2 = 0x03 -> busy high for cycles 1..8; done only in cycle 9; sum = 0x08, carry = 0.
- Overflow: in_1 = 0xFF, in_2 = 0x01 -> sum = 0x00, carry = 1. Also in_1 = 0xFF, in_2 = 0xFF -> sum = 0xFE, carry = 1.
- Start during RUN: pulse start with in_1 = 0x11, in_2 = 0x22 in cycle 4 of an active 0x05+0x03 op -> ignored; result 0x08; no extra done.
- Back-to-back: start held high with operands 0x10+0x20 then 0x7F+0x01 -> done in cycles 9 and 18; sums 0x30 then 0x80, carry 0; the first sum is held during the second RUN.
- Reset mid-op: assert reset in cycle 5 of a RUN -> next edge: busy = 0, done = 0, sum = 0x00, carry = 0, state IDLE; a following 0x02+0x02 gives 0x04.
- SERIAL_ADDER_SUB_EN defined:
  - sub = 1, in_1 = 0x05, in_2 = 0x07 -> sum = 0xFE, carry = 0.
  - sub = 1, in_1 = 0x07, in_2 = 0x05 -> sum = 0x02, carry = 1.
